// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle between a requester and the serial adder controller.
//   start   : request, honoured only while the controller is idle
//   a_in    : operand A, captured on the accepting edge
//   b_in    : operand B, captured on the accepting edge
//   cin     : carry-in, captured on the accepting edge
//   busy    : addition in progress
//   done    : one-cycle pulse when sum/cout are freshly valid
//   sum     : registered result, (a_in + b_in + cin) mod 2^WIDTH
//   cout    : registered carry-out of the MSB
// The master modport is the requester side; the slave modport is the controller side.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start,
    output a_in,
    output b_in,
    output cin,
    input  busy,
    input  done,
    input  sum,
    input  cout
  );

  modport slave (
    input  start,
    input  a_in,
    input  b_in,
    input  cin,
    output busy,
    output done,
    output sum,
    output cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller built around a single combinational full-adder cell.
// Operands are shifted out LSB first, one bit per clock; each sum bit is shifted into a result
// register from the top, and the cell's carry-out is registered as the next bit's carry-in.
//   clk    : system clock, all state updates on the rising edge
//   rst    : synchronous, active-high reset; overrides every other input
//   bus_io : slave side of serial_adder_ctrl_if (start/a_in/b_in/cin in,
//            busy/done/sum/cout out)
// Timing: accepting edge E0, bit edges E1..E(WIDTH), done high in the cycle after E(WIDTH).
// sum/cout are only written on the last bit edge, so partial results never appear.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus_io
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAdd  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Full-adder cell
  logic             fa_a, fa_b, fa_ci;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] r_next;

  always_comb begin
    fa_a   = a_sh_q[0];
    fa_b   = b_sh_q[0];
    fa_ci  = carry_q;
    fa_s   = fa_a ^ fa_b ^ fa_ci;
    fa_co  = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);
    r_next = {fa_s, r_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          a_sh_d  = bus_io.a_in;
          b_sh_d  = bus_io.b_in;
          carry_d = bus_io.cin;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        r_sh_d  = r_next;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CntLast) begin
          // Last bit: publish the whole result at once; cnt stays at WIDTH-1.
          sum_d   = r_next;
          cout_d  = fa_co;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus_io.busy = (state_q == StAdd);
  assign bus_io.done = (state_q == StDone);
  assign bus_io.sum  = sum_q;
  assign bus_io.cout = cout_q;

endmodule
